// File: rtl/mul_seq_ctrl.sv
// Sequential 32x32->64 multiplier controller that time-shares one external 16x16
// pipelined multiplier cell and applies signed-operand correction to the high word.
module mul_seq_ctrl #(
  parameter int MUL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic        busy,
  output logic        done,
  output logic [31:0] result_lo,
  output logic [31:0] result_hi,
  output logic [15:0] mul_a,
  output logic [15:0] mul_b,
  input  logic [31:0] mul_p
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_FIXUP,
    S_DONE
  } state_e;

  // sh encodes the partial-product weight: 0 -> <<0, 1 -> <<16, 2 -> <<32.
  typedef struct packed {
    logic       vld;
    logic [1:0] sh;
  } tag_t;

  localparam logic [1:0] DRAIN_LAST = 2'(MUL_LATENCY - 1);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] a_q, b_q;
  logic [1:0]  op_q;
  logic [63:0] acc_q, acc_d;
  logic [31:0] res_lo_q, res_hi_q;
  tag_t        tag_q [MUL_LATENCY];
  tag_t        tag_in, tag_out;
  logic [5:0]  shamt;
  logic [31:0] corr_a, corr_b;
  logic        accept;

  assign accept  = (state_q == S_IDLE) && start;
  assign tag_out = tag_q[MUL_LATENCY-1];
  assign shamt   = {tag_out.sh, 4'b0000};

  // Signed-operand correction terms; op 3 behaves as unsigned.
  assign corr_a = ((op_q == 2'd1 || op_q == 2'd2) && a_q[31]) ? b_q : 32'd0;
  assign corr_b = ((op_q == 2'd1) && b_q[31]) ? a_q : 32'd0;

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; otherwise synthesis would infer a latch to hold the old value.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mul_a   = 16'd0;
    mul_b   = 16'd0;
    tag_in  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
          cnt_d   = 2'd0;
        end
      end
      S_ISSUE: begin
        // k[0] picks the upper half of a, k[1] the upper half of b.
        mul_a      = cnt_q[0] ? a_q[31:16] : a_q[15:0];
        mul_b      = cnt_q[1] ? b_q[31:16] : b_q[15:0];
        tag_in.vld = 1'b1;
        tag_in.sh  = {1'b0, cnt_q[0]} + {1'b0, cnt_q[1]};
        if (cnt_q == 2'd3) begin
          state_d = S_DRAIN;
          cnt_d   = 2'd0;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      S_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          state_d = S_FIXUP;
          cnt_d   = 2'd0;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      S_FIXUP: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    acc_d = acc_q;
    if (accept) begin
      acc_d = 64'd0;
    end else if (tag_out.vld) begin
      acc_d = acc_q + (64'(mul_p) << shamt);
    end else if (state_q == S_FIXUP) begin
      acc_d = {acc_q[63:32] - corr_a - corr_b, acc_q[31:0]};
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the simulator runs the blocks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      op_q     <= 2'd0;
      acc_q    <= 64'd0;
      res_lo_q <= 32'd0;
      res_hi_q <= 32'd0;
    end else begin
      acc_q <= acc_d;
      if (accept) begin
        a_q  <= src1;
        b_q  <= src2;
        op_q <= op;
      end
      if (state_q == S_FIXUP) begin
        res_lo_q <= acc_d[31:0];
        res_hi_q <= acc_d[63:32];
      end
    end
  end

  // NOTE: the tag pipe is reset (unlike a plain data RAM) so products still in
  // flight in the multiplier cell are never accumulated after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_q <= '{default: '0};
    end else begin
      tag_q[0] <= tag_in;
      for (int i = 1; i < MUL_LATENCY; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign result_lo = res_lo_q;
  assign result_hi = res_hi_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Drives three sequencers (MUL_LATENCY 1..3) with shared stimulus; each has its
// own multiplier cell model, reference model and scoreboard.
module tb_mul_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] src1 = 32'd0;
  logic [31:0] src2 = 32'd0;

  logic        busy_w   [3];
  logic        done_w   [3];
  logic [31:0] res_lo_w [3];
  logic [31:0] res_hi_w [3];
  logic [15:0] mul_a_w  [3];
  logic [15:0] mul_b_w  [3];
  logic [31:0] mul_p_w  [3];
  int          pending  [3];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Full-width product straight from operand interpretation.
  function automatic logic [63:0] ref_mul(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb;
    sa = (o == 2'd1 || o == 2'd2) ? longint'($signed(a)) : longint'(a);
    sb = (o == 2'd1) ? longint'($signed(b)) : longint'(b);
    return 64'(sa * sb);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_lat
    localparam int L = g + 1;

    mul_seq_ctrl #(.MUL_LATENCY(L)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .op        (op),
      .src1      (src1),
      .src2      (src2),
      .busy      (busy_w[g]),
      .done      (done_w[g]),
      .result_lo (res_lo_w[g]),
      .result_hi (res_hi_w[g]),
      .mul_a     (mul_a_w[g]),
      .mul_b     (mul_b_w[g]),
      .mul_p     (mul_p_w[g])
    );

    // Multiplier cell: product valid L clocks after operands are presented; not reset.
    logic [31:0] p_pipe [L];
    always @(posedge clk) begin
      p_pipe[0] <= {16'd0, mul_a_w[g]} * {16'd0, mul_b_w[g]};
      for (int i = 1; i < L; i++) p_pipe[i] <= p_pipe[i-1];
    end
    assign mul_p_w[g] = p_pipe[L-1];

    int          busy_left = 0;
    logic [31:0] ca, cb;
    logic [63:0] last = 64'd0;
    logic [63:0] sb_q [$];

    always @(negedge clk) begin
      logic [15:0] ea, eb;
      int          k;
      if (!reset_n) begin
        busy_left = 0;
        sb_q.delete();
        last = 64'd0;
      end else begin
        check($sformatf("L%0d busy", L), 64'(busy_w[g]), 64'(busy_left > 0));
        check($sformatf("L%0d done", L), 64'(done_w[g]), 64'(busy_left == 1));
        if (done_w[g]) begin
          check($sformatf("L%0d done_with_empty_scoreboard", L), 64'(sb_q.size() == 0), 64'd0);
          if (sb_q.size() != 0) last = sb_q.pop_front();
        end
        check($sformatf("L%0d result", L), {res_hi_w[g], res_lo_w[g]}, last);
        ea = 16'd0;
        eb = 16'd0;
        if (busy_left >= 3 + L && busy_left <= 6 + L) begin
          k  = 6 + L - busy_left;
          ea = k[0] ? ca[31:16] : ca[15:0];
          eb = k[1] ? cb[31:16] : cb[15:0];
        end
        check($sformatf("L%0d mul_ab", L), 64'({mul_a_w[g], mul_b_w[g]}), 64'({ea, eb}));
        if (busy_left == 0) begin
          if (start) begin
            busy_left = 6 + L;
            ca = src1;
            cb = src2;
            sb_q.push_back(ref_mul(op, src1, src2));
          end
        end else begin
          busy_left--;
        end
      end
      pending[g] = sb_q.size();
    end
  end

  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    start = 1'b1; op = o; src1 = a; src2 = b;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'hFFFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'h0000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset busy[%0d]", i), 64'(busy_w[i]), 64'd0);
      check($sformatf("reset done[%0d]", i), 64'(done_w[i]), 64'd0);
      check($sformatf("reset result[%0d]", i), {res_hi_w[i], res_lo_w[i]}, 64'd0);
      check($sformatf("reset mul_ab[%0d]", i), 64'({mul_a_w[i], mul_b_w[i]}), 64'd0);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;

    do_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op(2'd1, 32'h8000_0000, 32'h8000_0000);
    do_op(2'd2, 32'hFFFF_FFFF, 32'h0000_0002);
    do_op(2'd3, 32'hFFFF_FFFF, 32'h0000_0002);
    do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);

    for (int n = 0; n < 24; n++) begin
      do_op(2'($urandom), pick_operand(), pick_operand());
    end

    // start held high; constant operands, then operands changing every cycle.
    @(posedge clk); #1;
    start = 1'b1; op = 2'd0; src1 = 32'h0001_2345; src2 = 32'h0001_0000;
    repeat (30) @(posedge clk);
    repeat (60) begin
      @(posedge clk); #1;
      op = 2'($urandom); src1 = pick_operand(); src2 = pick_operand();
    end
    @(posedge clk); #1;
    start = 1'b0;
    repeat (12) @(posedge clk);

    // Reset in ISSUE k=2, then a clean op on top of stale multiplier products.
    @(posedge clk); #1;
    start = 1'b1; op = 2'd0; src1 = 32'hDEAD_BEEF; src2 = 32'hCAFE_F00D;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("midop reset busy[%0d]", i), 64'(busy_w[i]), 64'd0);
      check($sformatf("midop reset done[%0d]", i), 64'(done_w[i]), 64'd0);
      check($sformatf("midop reset result[%0d]", i), {res_hi_w[i], res_lo_w[i]}, 64'd0);
      check($sformatf("midop reset mul_ab[%0d]", i), 64'({mul_a_w[i], mul_b_w[i]}), 64'd0);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    do_op(2'd0, 32'd3, 32'd5);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("post-reset result[%0d]", i), {res_hi_w[i], res_lo_w[i]}, 64'd15);
    end

    for (int i = 0; i < 3; i++) begin
      check($sformatf("scoreboard drained[%0d]", i), 64'(pending[i]), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Multi-cycle sequencer that produces a full 32x32->64 product by time-sharing one external 16x16 unsigned pipelined multiplier cell.
- Issues four partial products, accumulates them, then applies a signed-operand correction.
- Sits between the CPU execute-stage custom/extended-multiply path and the dedicated DSP multiplier.
- Supports unsigned x unsigned, signed x signed and signed x unsigned high-word operations.

Parameters:
- MUL_LATENCY, 1: clock cycles from mul_a/mul_b presented to mul_p valid. Legal range 1..3. Must match the attached multiplier cell's register configuration.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  request pulse; sampled only in IDLE
- op  in  2  operation: 0 = unsigned x unsigned, 1 = signed x signed, 2 = signed(src1) x unsigned(src2), 3 = treated as 0
- src1  in  32  multiplicand
- src2  in  32  multiplier
- busy  out  1  high from the cycle after start is accepted until done deasserts
- done  out  1  single-cycle pulse; result valid
- result_lo  out  32  product bits [31:0]
- result_hi  out  32  product bits [63:32], after correction
- mul_a  out  16  operand A to the multiplier cell
- mul_b  out  16  operand B to the multiplier cell
- mul_p  in  32  unsigned 32-bit product from the multiplier cell

Behaviour:
- Reset values (asynchronous, reset_n low): state=IDLE; busy=0; done=0; result_lo=0; result_hi=0; mul_a=0; mul_b=0; accumulator, tag pipe and index counter all 0.
- States: IDLE -> ISSUE -> DRAIN -> FIXUP -> DONE -> IDLE.
- IDLE:
  - On start=1 at a rising edge: capture src1, src2 and op into operand registers; clear the 64-bit accumulator; go to ISSUE.
  - start is ignored in every other state; operands are not recaptured.
- ISSUE (exactly 4 cycles, index k=0..3). mul_a/mul_b are driven combinationally from the captured operands and k:
  - k=0: a[15:0] x b[15:0], weight shift 0
  - k=1: a[31:16] x b[15:0], shift 16
  - k=2: a[15:0] x b[31:16], shift 16
  - k=3: a[31:16] x b[31:16], shift 32
  - A valid/shift tag enters a MUL_LATENCY-deep shift register each ISSUE cycle.
- Accumulation: when a tag exits the pipe, acc <= acc + (zero-extended mul_p << shift), computed modulo 2^64.
- Operand outputs outside ISSUE: mul_a/mul_b hold 0.
- DRAIN: lasts MUL_LATENCY cycles, until the final tag retires.
- FIXUP (1 cycle), applied to acc[63:32] modulo 2^32:
  - op=1: subtract (a[31] ? b : 0) and subtract (b[31] ? a : 0).
  - op=2: subtract (a[31] ? b : 0).
  - op=0 or 3: no change.
  - acc[31:0] is never modified.
- DONE (1 cycle): result_lo/result_hi load on entry, so they are valid in the same cycle done=1. Next cycle returns to IDLE.
- Result hold: results hold their value until the next DONE or reset.
- Handshake timing:
  - start accepted at edge E0.
  - busy=1 from E0 through the DONE cycle; busy=0 in IDLE.
  - done=1 exactly in cycle E0 + 6 + MUL_LATENCY.
  - Back-to-back: start may be asserted in the cycle after DONE; no start may be accepted during DONE.
- Reset mid-operation: immediate return to IDLE; outputs and the tag pipe clear; any in-flight mul_p is discarded, with no spurious accumulate after release.
- Arithmetic: no overflow flags; all wrap is modulo 2^64.

Test Plan:
- op=0, src1=src2=0xFFFFFFFF -> done at E0+7 (MUL_LATENCY=1); result_hi=0xFFFFFFFE, result_lo=0x00000001; busy high for 7 cycles; mul_a/mul_b sequence (0xFFFF,0xFFFF) x4.
- op=1, src1=src2=0xFFFFFFFF (-1 x -1) -> result_hi=0x00000000, result_lo=0x00000001; also src1=src2=0x80000000 -> result_hi=0x40000000, result_lo=0.
- op=2, src1=0xFFFFFFFF, src2=0x00000002 -> result_hi=0xFFFFFFFF, result_lo=0xFFFFFFFE; op=3 on the same operands -> result_hi=0x00000001, result_lo=0xFFFFFFFE.
- start held high continuously, op=0, src1=0x00012345, src2=0x00010000 while busy, operands changed mid-op -> one result per op, results 0x00000001/0x23450000 from the captured operands; next start accepted the cycle after done; done never asserts two cycles in a row.
- reset_n pulsed low in ISSUE k=2 -> busy/done/results=0 immediately; new op 3x5 (op=0) after release -> result_lo=15, result_hi=0, with no contamination.
- Repeat the first three tests with MUL_LATENCY=2 and 3 and a matching multiplier model -> identical results; done at E0+8 and E0+9.
